// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_return_stack
// Purpose  : Program-counter sequencer with a hardware return-address stack.
//            Produces the fetch address each cycle and handles sequential
//            fetch, absolute jump, jump-to-subroutine, return/peek and
//            relative branch. Stack misuse is reported through sticky
//            overflow and underflow flags.
// Ports    : clk             - clock, rising edge
//            rst             - asynchronous reset, active low
//            stall           - hold all state this cycle
//            halt            - sticky halt request
//            pc_src          - 00 PC+1, 01 jump, 10 return, 11 branch taken
//            stack_push      - push PC+1 (jsb)
//            stack_pop       - pop top of stack (ret)
//            jump_addr       - absolute jump target
//            branch_off      - signed offset relative to PC+1
//            pc              - current fetch address
//            halted          - sequencer frozen
//            sp              - stack depth, 0..DEPTH
//            stack_overflow  - sticky: push attempted while full
//            stack_underflow - sticky: pop/return attempted while empty
// Revision : 1.0 - initial release
// ============================================================================
module pc_return_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 8,
    parameter int OFF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     halt,
    input  logic [1:0]               pc_src,
    input  logic                     stack_push,
    input  logic                     stack_pop,
    input  logic [PC_W-1:0]          jump_addr,
    input  logic [OFF_W-1:0]         branch_off,
    output logic [PC_W-1:0]          pc,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stack_overflow,
    output logic                     stack_underflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    localparam logic [1:0] c_SRC_INC  = 2'b00;
    localparam logic [1:0] c_SRC_JMP  = 2'b01;
    localparam logic [1:0] c_SRC_RET  = 2'b10;
    localparam logic [1:0] c_SRC_BRA  = 2'b11;

    logic [PC_W-1:0] r_pc;
    logic [SP_W-1:0] r_sp;
    logic            r_halted;
    logic            r_ovf;
    logic            r_unf;
    logic [PC_W-1:0] r_stack [DEPTH];

    logic            w_upd;
    logic            w_empty;
    logic            w_full;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_top;
    logic [AW-1:0]   w_top_idx;
    logic [AW-1:0]   w_wr_idx;
    logic            w_wr_en;

    // Reset is folded in so a write cannot land while rst is held low.
    assign w_upd     = rst & ~stall & ~r_halted;
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_W'(DEPTH));
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_off_ext = PC_W'(signed'(branch_off));
    assign w_top_idx = AW'(r_sp - SP_W'(1));
    assign w_wr_idx  = AW'(r_sp);
    assign w_top     = r_stack[w_top_idx];

    // A simultaneous pop cancels the push; a halt cancels everything.
    assign w_wr_en   = w_upd & ~halt & stack_push & ~stack_pop & ~w_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= '0;
            r_sp     <= '0;
            r_halted <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (w_upd) begin
            if (halt) begin
                r_halted <= 1'b1;
            end else begin
                case (pc_src)
                    c_SRC_INC: r_pc <= w_pc_inc;
                    c_SRC_JMP: r_pc <= jump_addr;
                    c_SRC_RET: begin
                        // Return target comes from the pre-update stack.
                        if (w_empty) begin
                            r_pc  <= w_pc_inc;
                            r_unf <= 1'b1;
                        end else begin
                            r_pc <= w_top;
                        end
                    end
                    c_SRC_BRA: r_pc <= w_pc_inc + w_off_ext;
                    default:   r_pc <= w_pc_inc;
                endcase

                if (stack_pop) begin
                    if (w_empty) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_sp <= r_sp - SP_W'(1);
                    end
                end else if (stack_push) begin
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_sp <= r_sp + SP_W'(1);
                    end
                end
            end
        end
    end

    // Stack storage carries no reset; its contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign pc              = r_pc;
    assign halted          = r_halted;
    assign sp              = r_sp;
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_return_stack
// Purpose  : Directed, table-driven self-checking bench for pc_return_stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_return_stack;

    localparam int PC_W  = 12;
    localparam int DEPTH = 8;
    localparam int OFF_W = 8;
    localparam int SP_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic             stall;
        logic             halt;
        logic [1:0]       src;
        logic             push;
        logic             pop;
        logic [PC_W-1:0]  jaddr;
        logic [OFF_W-1:0] boff;
        logic [PC_W-1:0]  e_pc;
        logic [SP_W-1:0]  e_sp;
        logic             e_halted;
        logic             e_ovf;
        logic             e_unf;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             halt;
    logic [1:0]       pc_src;
    logic             stack_push;
    logic             stack_pop;
    logic [PC_W-1:0]  jump_addr;
    logic [OFF_W-1:0] branch_off;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [SP_W-1:0]  sp;
    logic             stack_overflow;
    logic             stack_underflow;

    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];

    // Sticky expectations used while building the table.
    logic g_halted;
    logic g_ovf;
    logic g_unf;

    pc_return_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .OFF_W (OFF_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .halt            (halt),
        .pc_src          (pc_src),
        .stack_push      (stack_push),
        .stack_pop       (stack_pop),
        .jump_addr       (jump_addr),
        .branch_off      (branch_off),
        .pc              (pc),
        .halted          (halted),
        .sp              (sp),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic st, input logic hl, input logic [1:0] src,
                       input logic psh, input logic pp,
                       input logic [PC_W-1:0] ja, input logic [OFF_W-1:0] bo,
                       input logic [PC_W-1:0] epc, input logic [SP_W-1:0] esp);
        vec_t v;
        v.stall = st;  v.halt = hl;  v.src = src;
        v.push  = psh; v.pop  = pp;  v.jaddr = ja; v.boff = bo;
        v.e_pc  = epc; v.e_sp = esp;
        v.e_halted = g_halted; v.e_ovf = g_ovf; v.e_unf = g_unf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [PC_W-1:0] epc,
                           input logic [SP_W-1:0] esp, input logic eh,
                           input logic eo, input logic eu);
        chk("pc",        idx, 32'(pc),              32'(epc));
        chk("sp",        idx, 32'(sp),              32'(esp));
        chk("halted",    idx, 32'(halted),          32'(eh));
        chk("overflow",  idx, 32'(stack_overflow),  32'(eo));
        chk("underflow", idx, 32'(stack_underflow), 32'(eu));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        g_halted = 1'b0; g_ovf = 1'b0; g_unf = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 1; i <= 5; i++)
            add(0, 0, 2'b00, 0, 0, 12'h000, 8'h00, 12'(i), 0);
        add(0, 0, 2'b11, 0, 0, 12'h000, 8'hFA, 12'h000, 0);      // 5+1-6 = 0
        add(0, 0, 2'b01, 0, 0, 12'h010, 8'h00, 12'h010, 0);
        add(0, 0, 2'b01, 1, 0, 12'h200, 8'h00, 12'h200, 1);      // jsb, saves 0x011
        add(0, 0, 2'b00, 0, 0, 12'h000, 8'h00, 12'h201, 1);
        add(0, 0, 2'b00, 0, 0, 12'h000, 8'h00, 12'h202, 1);
        add(0, 0, 2'b00, 0, 0, 12'h000, 8'h00, 12'h203, 1);
        add(0, 0, 2'b10, 0, 1, 12'h000, 8'h00, 12'h011, 0);      // ret
        add(0, 0, 2'b01, 0, 0, 12'hFFE, 8'h00, 12'hFFE, 0);
        add(0, 0, 2'b11, 0, 0, 12'h000, 8'h03, 12'h002, 0);      // branch wraps
        add(0, 0, 2'b01, 0, 0, 12'hFFF, 8'h00, 12'hFFF, 0);
        add(0, 0, 2'b00, 0, 0, 12'h000, 8'h00, 12'h000, 0);      // PC+1 wraps
        add(0, 0, 2'b01, 0, 0, 12'h020, 8'h00, 12'h020, 0);
        // Nested jsb: first saves 0x021, the rest save 0x101.
        for (int i = 1; i <= 8; i++)
            add(0, 0, 2'b01, 1, 0, 12'h100, 8'h00, 12'h100, SP_W'(i));
        g_ovf = 1'b1;
        add(0, 0, 2'b01, 1, 0, 12'h100, 8'h00, 12'h100, 8);      // 9th jsb overflows
        add(0, 0, 2'b10, 0, 0, 12'h000, 8'h00, 12'h101, 8);      // peek
        for (int i = 7; i >= 1; i--)
            add(0, 0, 2'b10, 0, 1, 12'h000, 8'h00, 12'h101, SP_W'(i));
        add(0, 0, 2'b10, 0, 1, 12'h000, 8'h00, 12'h021, 0);
        g_unf = 1'b1;
        add(0, 0, 2'b10, 0, 1, 12'h000, 8'h00, 12'h022, 0);      // empty ret: PC+1
        add(0, 0, 2'b01, 1, 0, 12'h300, 8'h00, 12'h300, 1);
        add(0, 0, 2'b00, 1, 1, 12'h000, 8'h00, 12'h301, 0);      // pop wins over push
        // jsb held by stall for three cycles, then taken once.
        for (int i = 0; i < 3; i++)
            add(1, 0, 2'b01, 1, 0, 12'h400, 8'h00, 12'h301, 0);
        add(0, 0, 2'b01, 1, 0, 12'h400, 8'h00, 12'h400, 1);      // saves 0x302
        add(0, 0, 2'b00, 0, 0, 12'h000, 8'h00, 12'h401, 1);
        add(0, 0, 2'b10, 0, 1, 12'h000, 8'h00, 12'h302, 0);
        add(0, 0, 2'b01, 0, 0, 12'h030, 8'h00, 12'h030, 0);
        g_halted = 1'b1;
        add(0, 1, 2'b01, 0, 0, 12'h555, 8'h00, 12'h030, 0);      // halt ignores jump
        for (int i = 0; i < 10; i++)
            add(0, 0, 2'b01, 1, 0, 12'h555, 8'h00, 12'h030, 0);

        // ---------------- reset ----------------
        rst = 1'b0; stall = 1'b0; halt = 1'b0; pc_src = 2'b00;
        stack_push = 1'b0; stack_pop = 1'b0; jump_addr = '0; branch_off = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 12'h000, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // ---------------- table loop ----------------
        foreach (tbl[i]) begin
            stall      = tbl[i].stall;
            halt       = tbl[i].halt;
            pc_src     = tbl[i].src;
            stack_push = tbl[i].push;
            stack_pop  = tbl[i].pop;
            jump_addr  = tbl[i].jaddr;
            branch_off = tbl[i].boff;
            @(posedge clk);
            #1;
            chk_all(i, tbl[i].e_pc, tbl[i].e_sp, tbl[i].e_halted,
                    tbl[i].e_ovf, tbl[i].e_unf);
        end

        // ---------------- asynchronous reset mid-halt ----------------
        #3;
        rst = 1'b0;
        #1;
        chk_all(1000, 12'h000, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall = 1'b0; halt = 1'b0; pc_src = 2'b00;
        stack_push = 1'b0; stack_pop = 1'b0;
        @(posedge clk);
        #1;
        chk_all(1001, 12'h001, 0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
